seg7_decoder_rx: RTL and testbench

- Receive side of the datapath's 7-segment result bus: samples a 7-bit segment pattern and waits until it has been stable for a programmable number of cycles.
- Decodes the stable pattern back to a 4-bit nibble and hands it off over a valid/ready interface.
- Sits between the display bus (from the ALU/encoder) and any checker or controller that needs the numeric result; flags undecodable patterns and values lost to backpressure.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_to_nibble.sv | 35 +++
 rtl/seg7_decoder_rx.sv | 151 +++++++++++++++
 tb/tb_seg7_decoder_rx.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment result bus: segment encodings (bit6=a .. bit0=g)
// and the receiver state type.
package seg7_pkg;

    localparam int unsigned SEG7_W = 7;

    localparam logic [SEG7_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG7_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG7_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG7_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG7_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG7_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG7_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG7_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG7_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG7_W-1:0] SEG_9 = 7'b1111011;
    localparam logic [SEG7_W-1:0] SEG_A = 7'b1110111;
    localparam logic [SEG7_W-1:0] SEG_B = 7'b0011111;
    localparam logic [SEG7_W-1:0] SEG_C = 7'b1001110;
    localparam logic [SEG7_W-1:0] SEG_D = 7'b0111101;
    localparam logic [SEG7_W-1:0] SEG_E = 7'b1001111;
    localparam logic [SEG7_W-1:0] SEG_F = 7'b1000111;

    typedef enum logic [1:0] {IDLE, SETTLE, EMIT} seg7_rx_state_t;

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational segment-pattern to nibble lookup; hit_o=0 for any pattern
// outside the code table (nibble_o is then 0).
module seg7_to_nibble
    import seg7_pkg::*;
(
    input  logic [SEG7_W-1:0] seg_i,
    output logic [3:0]        nibble_o,
    output logic              hit_o
);

    always_comb begin
        nibble_o = '0;
        hit_o    = 1'b1;
        case (seg_i)
            SEG_0: nibble_o = 4'h0;
            SEG_1: nibble_o = 4'h1;
            SEG_2: nibble_o = 4'h2;
            SEG_3: nibble_o = 4'h3;
            SEG_4: nibble_o = 4'h4;
            SEG_5: nibble_o = 4'h5;
            SEG_6: nibble_o = 4'h6;
            SEG_7: nibble_o = 4'h7;
            SEG_8: nibble_o = 4'h8;
            SEG_9: nibble_o = 4'h9;
            SEG_A: nibble_o = 4'hA;
            SEG_B: nibble_o = 4'hB;
            SEG_C: nibble_o = 4'hC;
            SEG_D: nibble_o = 4'hD;
            SEG_E: nibble_o = 4'hE;
            SEG_F: nibble_o = 4'hF;
            default: hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_decoder_rx.sv
// 7-segment bus receiver: debounces seg_in for STABLE_CYCLES samples, decodes it and
// offers the nibble over valid/ready. Define SEG7_RX_SYNC_EN to add a 2-flop input synchronizer.
module seg7_decoder_rx
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [SEG7_W-1:0] seg_in,
    output logic [3:0]        value_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_o,
    output logic              overrun_o,
    input  logic              clear_i
);

    localparam int unsigned     CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG7_W-1:0] seg_s;
    seg7_rx_state_t    state_q, state_d;
    logic [SEG7_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              have_last_q, have_last_d;
    logic [SEG7_W-1:0] last_pat_q, last_pat_d;
    logic [3:0]        value_q, value_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              overrun_q, overrun_d;
    logic [3:0]        nib;
    logic              hit;
    logic              changed;
    logic              stable;

`ifdef SEG7_RX_SYNC_EN
    logic [SEG7_W-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= seg_in;
            sync2_q <= sync1_q;
        end
    end

    assign seg_s = sync2_q;
`else
    assign seg_s = seg_in;
`endif

    seg7_to_nibble u_lookup (
        .seg_i    (prev_q),
        .nibble_o (nib),
        .hit_o    (hit)
    );

    assign changed = (seg_s != prev_q);
    assign stable  = (cnt_q == CNT_MAX);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        have_last_d = have_last_q;
        last_pat_d  = last_pat_q;
        value_d     = value_q;
        valid_d     = valid_q;
        err_d       = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            cnt_d       = '0;
            prev_d      = seg_s;
            have_last_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // IDLE captures the bus so the enabling edge counts as the first sample
                    cnt_d       = '0;
                    prev_d      = seg_s;
                    have_last_d = 1'b0;
                    state_d     = SETTLE;
                end
                default: begin
                    if (changed) begin
                        prev_d = seg_s;
                        cnt_d  = '0;
                    end else if (!stable) begin
                        cnt_d = cnt_q + 1'b1;
                    end

                    if (state_q == SETTLE) begin
                        if (stable && (!have_last_q || (prev_q != last_pat_q))) begin
                            last_pat_d  = prev_q;
                            have_last_d = 1'b1;
                            if (hit) begin
                                value_d = nib;
                                valid_d = 1'b1;
                                state_d = EMIT;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end else if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = SETTLE;
                    end
                end
            endcase
        end

        overrun_d = (enable && (state_q == EMIT) && changed) || (overrun_q && !clear_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            cnt_q       <= '0;
            have_last_q <= 1'b0;
            last_pat_q  <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            have_last_q <= have_last_d;
            last_pat_q  <= last_pat_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign value_o   = value_q;
    assign out_valid = valid_q;
    assign err_o     = err_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_seg7_decoder_rx.sv
// Self-checking bench for seg7_decoder_rx: directed scenarios plus randomized traffic
// compared every cycle against a sample-count based reference model.
module tb_seg7_decoder_rx;

    localparam int STABLE = 4;
    localparam logic [6:0] TBL [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] seg_in = '0;
    logic [3:0] value_o;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       err_o;
    logic       overrun_o;
    logic       clear_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: counts consecutive identical samples taken while enabled
    bit         m_active;
    logic [6:0] m_run_pat;
    int         m_run_len;
    logic [6:0] m_last;
    bit         m_have;
    logic       m_valid;
    logic [3:0] m_value;
    logic       m_err;
    logic       m_ovr;

    seg7_decoder_rx #(.STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .seg_in    (seg_in),
        .value_o   (value_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_o     (err_o),
        .overrun_o (overrun_o),
        .clear_i   (clear_i)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (TBL[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_run_pat = '0; m_run_len = 0; m_last = '0; m_have = 0;
        m_valid = 1'b0; m_value = '0; m_err = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic [6:0] seg, input logic rdy, input logic clr);
        int   idx;
        logic set_ovr;
        set_ovr = 1'b0;
        m_err   = 1'b0;
        if (!en) begin
            m_active = 0; m_valid = 1'b0; m_have = 0;
        end else if (!m_active) begin
            m_active = 1; m_run_pat = seg; m_run_len = 1; m_have = 0;
        end else begin
            set_ovr = m_valid && (seg != m_run_pat);
            if (m_valid) begin
                if (rdy) m_valid = 1'b0;
            end else if (m_run_len >= STABLE && (!m_have || m_run_pat != m_last)) begin
                m_last = m_run_pat;
                m_have = 1;
                idx = decode(m_run_pat);
                if (idx >= 0) begin
                    m_valid = 1'b1;
                    m_value = 4'(idx);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (seg != m_run_pat) begin
                m_run_pat = seg;
                m_run_len = 1;
            end else begin
                m_run_len++;
            end
        end
        m_ovr = set_ovr || (m_ovr && !clr);
    endtask

    task automatic step(input logic en, input logic [6:0] seg, input logic rdy, input logic clr);
        enable = en; seg_in = seg; out_ready = rdy; clear_i = clr;
        model_edge(en, seg, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; seg_in = '0; out_ready = 1'b0; clear_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; seg_in = TBL[0]; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, value_o, err_o, overrun_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset outputs act %b exp %b", {out_valid, value_o, err_o, overrun_o}, 7'b0);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        int nvalid = 0;
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, TBL[0], 1'b1, 1'b0);
            if (out_valid) nvalid++;
            checks++;
            if ({out_valid, value_o, err_o, overrun_o} !== {m_valid, m_value, m_err, m_ovr}) begin
                errors++;
                $display("FAIL single step%0d act %b exp %b", i,
                         {out_valid, value_o, err_o, overrun_o}, {m_valid, m_value, m_err, m_ovr});
            end
            if (i == STABLE + 1) begin
                checks++;
                if (!(out_valid === 1'b1 && value_o === 4'h0)) begin
                    errors++;
                    $display("FAIL single_latency act v=%b val=%h exp v=1 val=0", out_valid, value_o);
                end
            end
        end
        checks++;
        if (nvalid != 1) begin
            errors++;
            $display("FAIL single_once act %0d exp 1", nvalid);
        end
    endtask

    task automatic test_glitch();
        int first = -1;
        bit saw_one = 0;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, (i <= 3) ? TBL[1] : TBL[2], 1'b1, 1'b0);
            if (out_valid && first < 0) first = i;
            if (out_valid && value_o == 4'h1) saw_one = 1;
            checks++;
            if ({out_valid, value_o, err_o, overrun_o} !== {m_valid, m_value, m_err, m_ovr}) begin
                errors++;
                $display("FAIL glitch step%0d act %b exp %b", i,
                         {out_valid, value_o, err_o, overrun_o}, {m_valid, m_value, m_err, m_ovr});
            end
        end
        checks++;
        if (first != 4 + STABLE || saw_one) begin
            errors++;
            $display("FAIL glitch_timing act first=%0d saw1=%0d exp first=%0d saw1=0", first, saw_one, 4 + STABLE);
        end
    endtask

    task automatic test_invalid();
        int nerr = 0;
        int at = -1;
        bit anyv = 0;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 7'b1010101, 1'b1, 1'b0);
            if (err_o) begin nerr++; at = i; end
            if (out_valid) anyv = 1;
            checks++;
            if ({out_valid, value_o, err_o, overrun_o} !== {m_valid, m_value, m_err, m_ovr}) begin
                errors++;
                $display("FAIL invalid step%0d act %b exp %b", i,
                         {out_valid, value_o, err_o, overrun_o}, {m_valid, m_value, m_err, m_ovr});
            end
        end
        checks++;
        if (nerr != 1 || at != STABLE + 1 || anyv) begin
            errors++;
            $display("FAIL invalid_once act n=%0d at=%0d v=%0d exp n=1 at=%0d v=0", nerr, at, anyv, STABLE + 1);
        end
    endtask

    task automatic test_backpressure();
        bit seen_f = 0;
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, TBL[3], 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, TBL[15], 1'b0, 1'b0);
            checks++;
            if ({out_valid, value_o, err_o, overrun_o} !== {m_valid, m_value, m_err, m_ovr}) begin
                errors++;
                $display("FAIL backpr step%0d act %b exp %b", i,
                         {out_valid, value_o, err_o, overrun_o}, {m_valid, m_value, m_err, m_ovr});
            end
        end
        checks++;
        if ({out_valid, value_o, overrun_o} !== {1'b1, 4'h3, 1'b1}) begin
            errors++;
            $display("FAIL backpr_hold act v=%b val=%h ovr=%b exp v=1 val=3 ovr=1", out_valid, value_o, overrun_o);
        end
        step(1'b1, TBL[15], 1'b1, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            step(1'b1, TBL[15], 1'b0, 1'b0);
            if (out_valid && value_o == 4'hF) seen_f = 1;
        end
        checks++;
        if (!seen_f) begin
            errors++;
            $display("FAIL backpr_next act v=%b val=%h exp v=1 val=F", out_valid, value_o);
        end
        step(1'b1, TBL[15], 1'b1, 1'b1);
        checks++;
        if (overrun_o !== 1'b0 || overrun_o !== m_ovr) begin
            errors++;
            $display("FAIL backpr_clear act %b exp 0", overrun_o);
        end
    endtask

    task automatic test_sequence();
        int hs = 0;
        logic [3:0] got [$];
        logic [3:0] seq [3] = '{4'h5, 4'h6, 4'h5};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            for (int i = 1; i <= 6; i++) begin
                if (out_valid) begin hs++; got.push_back(value_o); end
                step(1'b1, (s == 3) ? TBL[5] : TBL[seq[s]], 1'b1, 1'b0);
                checks++;
                if ({out_valid, value_o, err_o, overrun_o} !== {m_valid, m_value, m_err, m_ovr}) begin
                    errors++;
                    $display("FAIL sequence s%0d step%0d act %b exp %b", s, i,
                             {out_valid, value_o, err_o, overrun_o}, {m_valid, m_value, m_err, m_ovr});
                end
            end
        end
        checks++;
        if (hs != 3 || got[0] != 4'h5 || got[1] != 4'h6 || got[2] != 4'h5) begin
            errors++;
            $display("FAIL sequence_hs act n=%0d exp n=3 values 5,6,5", hs);
        end
    endtask

    task automatic test_disable();
        int first = -1;
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, TBL[10], 1'b0, 1'b0);
        step(1'b0, TBL[10], 1'b0, 1'b0);
        checks++;
        if ({out_valid, value_o, overrun_o} !== {1'b0, 4'hA, 1'b0}) begin
            errors++;
            $display("FAIL disable_drop act v=%b val=%h ovr=%b exp v=0 val=A ovr=0", out_valid, value_o, overrun_o);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, TBL[10], 1'b0, 1'b0);
            if (out_valid && first < 0) first = i;
            checks++;
            if ({out_valid, value_o, err_o, overrun_o} !== {m_valid, m_value, m_err, m_ovr}) begin
                errors++;
                $display("FAIL disable step%0d act %b exp %b", i,
                         {out_valid, value_o, err_o, overrun_o}, {m_valid, m_value, m_err, m_ovr});
            end
        end
        checks++;
        if (first != STABLE + 1) begin
            errors++;
            $display("FAIL disable_rereport act %0d exp %0d", first, STABLE + 1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, TBL[8], 1'b0, 1'b0);
        step(1'b1, TBL[9], 1'b0, 1'b0);
        step(1'b1, TBL[9], 1'b0, 1'b0);
        checks++;
        if ({out_valid, value_o, overrun_o} !== {1'b1, 4'h8, 1'b1}) begin
            errors++;
            $display("FAIL areset_pre act %b exp %b", {out_valid, value_o, overrun_o}, {1'b1, 4'h8, 1'b1});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, value_o, err_o, overrun_o} !== 7'b0) begin
            errors++;
            $display("FAIL areset_now act %b exp %b", {out_valid, value_o, err_o, overrun_o}, 7'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [6:0] pat;
        logic       en;
        int         hold;
        int         n = 0;
        do_reset();
        while (n < 400) begin
            pat  = ($urandom_range(0, 4) == 0) ? 7'($urandom) : TBL[$urandom_range(0, 15)];
            en   = ($urandom_range(0, 19) != 0);
            hold = $urandom_range(1, 8);
            for (int i = 0; i < hold; i++) begin
                step(en, pat, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
                n++;
                checks++;
                if ({out_valid, value_o, err_o, overrun_o} !== {m_valid, m_value, m_err, m_ovr}) begin
                    errors++;
                    $display("FAIL random cyc%0d act %b exp %b", n,
                             {out_valid, value_o, err_o, overrun_o}, {m_valid, m_value, m_err, m_ovr});
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_glitch();
        test_invalid();
        test_backpressure();
        test_sequence();
        test_disable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
